// File: rtl/ahb_mem_responder.sv
// ahb_mem_responder: AHB-Lite word memory subordinate with pipelined phases,
// programmable wait states, a two-cycle ERROR response and read-after-write forwarding.
module ahb_mem_responder #(
    parameter int COLS        = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      HTRANS,
    input  logic            HWRITE,
    input  logic [COLS-1:0] HADDR,
    input  logic [COLS-1:0] HWDATA,
    output logic [COLS-1:0] HRDATA,
    output logic            HREADY,
    output logic            HRESP
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [COLS-1:0] LIMIT = COLS'(DEPTH * 4);
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;
    state_t          state_q;
    logic            hready_q, hresp_q, wr_q;
    logic [3:0]      cnt_q;
    logic [AW-1:0]   idx_q;
    logic [COLS-1:0] rdata_q;
    logic [COLS-1:0] mem [DEPTH];
    logic            acc, a_err, fwd, unused_ok;
    logic [AW-1:0]   a_idx;
    assign acc       = hready_q && HTRANS[1];
    assign a_err     = (HADDR[1:0] != 2'b00) || (HADDR >= LIMIT);
    assign a_idx     = HADDR[AW+1:2];
    // a write completing this cycle to the same word must win over the stale array entry
    assign fwd       = (state_q == S_DONE) && wr_q && (idx_q == a_idx);
    assign unused_ok = HTRANS[0];
    assign HREADY    = hready_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = rdata_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            wr_q     <= 1'b0;
        end else begin
            rdata_q <= '0;
            if (acc) begin
                idx_q <= a_idx;
                wr_q  <= HWRITE;
                cnt_q <= '0;
                if (a_err) begin
                    state_q  <= S_ERR1;
                    hready_q <= 1'b0;
                    hresp_q  <= 1'b1;
                end else if (WS != 4'd0) begin
                    state_q  <= S_WAIT;
                    hready_q <= 1'b0;
                    hresp_q  <= 1'b0;
                end else begin
                    state_q  <= S_DONE;
                    hready_q <= 1'b1;
                    hresp_q  <= 1'b0;
                    if (!HWRITE) rdata_q <= fwd ? HWDATA : mem[a_idx];
                end
            end else begin
                case (state_q)
                    S_WAIT: begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == WS) begin
                            state_q  <= S_DONE;
                            hready_q <= 1'b1;
                            if (!wr_q) rdata_q <= mem[idx_q];
                        end
                    end
                    S_ERR1: begin
                        state_q  <= S_ERR2;
                        hready_q <= 1'b1;
                        hresp_q  <= 1'b1;
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= 1'b0;
                    end
                endcase
            end
        end
    end
    always_ff @(posedge clk) begin
        if (state_q == S_DONE && wr_q) mem[idx_q] <= HWDATA;
    end
endmodule

// File: tb/tb_ahb_mem_responder.sv
// tb_ahb_mem_responder: three responders (0, 2 and 3 wait states) driven by directed and
// random traffic, checked against a per-transfer expected-response schedule.
module tb_ahb_mem_responder;
    localparam int WSV [3] = '{0, 2, 3};
    localparam int LIM = 64;
    typedef struct packed {
        logic       rdy;
        logic       resp;
        logic       rd;
        logic       wr;
        logic [3:0] idx;
    } ph_t;
    localparam ph_t IDLE_PH = 8'b1000_0000;
    localparam ph_t WAIT_PH = 8'b0000_0000;
    localparam ph_t ERR1_PH = 8'b0100_0000;
    localparam ph_t ERR2_PH = 8'b1100_0000;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  htrans [3];
    logic        hwrite [3];
    logic [31:0] haddr [3], hwdata [3], hrdata [3];
    logic        hready [3], hresp [3];
    int unsigned ncmp = 0, nerr = 0;
    logic [31:0] mm [3][16];
    bit          kn [3][16];
    ph_t         sch [3][8];
    int          hd [3], ln [3];
    always #5 clk = ~clk;
    ahb_mem_responder #(.COLS(32), .DEPTH(16), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst), .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HADDR(haddr[0]),
        .HWDATA(hwdata[0]), .HRDATA(hrdata[0]), .HREADY(hready[0]), .HRESP(hresp[0]));
    ahb_mem_responder #(.COLS(32), .DEPTH(16), .WAIT_STATES(2)) u1 (
        .clk(clk), .rst(rst), .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HADDR(haddr[1]),
        .HWDATA(hwdata[1]), .HRDATA(hrdata[1]), .HREADY(hready[1]), .HRESP(hresp[1]));
    ahb_mem_responder #(.COLS(32), .DEPTH(16), .WAIT_STATES(3)) u2 (
        .clk(clk), .rst(rst), .HTRANS(htrans[2]), .HWRITE(hwrite[2]), .HADDR(haddr[2]),
        .HWDATA(hwdata[2]), .HRDATA(hrdata[2]), .HREADY(hready[2]), .HRESP(hresp[2]));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask
    // one bus cycle: compare outputs at negedge, then advance the expected schedule at posedge
    task automatic tick();
        ph_t cur [3];
        logic [31:0] a;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            cur[d] = (hd[d] < ln[d]) ? sch[d][hd[d]] : IDLE_PH;
            check($sformatf("u%0d.hready", d), 32'(hready[d]), 32'(cur[d].rdy));
            check($sformatf("u%0d.hresp", d), 32'(hresp[d]), 32'(cur[d].resp));
            if (!cur[d].rd || kn[d][cur[d].idx])
                check($sformatf("u%0d.hrdata", d), hrdata[d], cur[d].rd ? mm[d][cur[d].idx] : 32'd0);
        end
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            a = haddr[d];
            if (cur[d].wr) begin
                mm[d][cur[d].idx] = hwdata[d];
                kn[d][cur[d].idx] = 1'b1;
            end
            if (hd[d] < ln[d]) hd[d]++;
            if (cur[d].rdy && htrans[d][1]) begin
                hd[d] = 0;
                if (a[1:0] != 2'b00 || a >= LIM) begin
                    sch[d][0] = ERR1_PH;
                    sch[d][1] = ERR2_PH;
                    ln[d] = 2;
                end else begin
                    for (int k = 0; k < WSV[d]; k++) sch[d][k] = WAIT_PH;
                    sch[d][WSV[d]] = {1'b1, 1'b0, !hwrite[d], hwrite[d], a[5:2]};
                    ln[d] = WSV[d] + 1;
                end
            end
        end
        #1;
    endtask
    task automatic set(input int d, input logic [1:0] t, input logic w, input logic [31:0] a,
                       input logic [31:0] wd);
        htrans[d] = t;
        hwrite[d] = w;
        haddr[d]  = a;
        hwdata[d] = wd;
    endtask
    task automatic single(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
        set(d, 2'b10, w, a, wd);
        tick();
        htrans[d] = 2'b00;
        for (int k = 0; k < 8 && hd[d] < ln[d]; k++) tick();
    endtask
    task automatic do_reset();
        for (int d = 0; d < 3; d++) htrans[d] = 2'b00;
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("u%0d.rst_hready", d), 32'(hready[d]), 32'd1);
            check($sformatf("u%0d.rst_hresp", d), 32'(hresp[d]), 32'd0);
            check($sformatf("u%0d.rst_hrdata", d), hrdata[d], 32'd0);
            hd[d] = 0;
            ln[d] = 0;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask
    task automatic drive_rand(input int d);
        int r;
        r = $urandom_range(0, 9);
        htrans[d] = r < 3 ? 2'b00 : r < 4 ? 2'b01 : r < 7 ? 2'b10 : 2'b11;
        r = $urandom_range(0, 15);
        haddr[d] = r == 0 ? 32'($urandom) : r == 1 ? 32'(LIM) : r == 2 ? 32'(LIM - 4) :
                   r == 3 ? 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3)) :
                   32'($urandom_range(0, 15) * 4);
        hwrite[d] = 1'($urandom_range(0, 1));
        if (!(hd[d] > 0 && hd[d] < ln[d])) hwdata[d] = $urandom;
    endtask
    initial begin
        for (int d = 0; d < 3; d++) set(d, 2'b00, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("u%0d.init_hready", d), 32'(hready[d]), 32'd1);
            check($sformatf("u%0d.init_hresp", d), 32'(hresp[d]), 32'd0);
            check($sformatf("u%0d.init_hrdata", d), hrdata[d], 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        // back-to-back write then read of the same word: read data is forwarded
        set(0, 2'b10, 1'b1, 32'h10, 32'd0);
        tick();
        set(0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        tick();
        set(0, 2'b00, 1'b0, 32'h0, 32'hDEADBEEF);
        tick();
        tick();
        // wait-stated read with address/direction toggled while HREADY is low
        single(2, 1'b1, 32'h20, 32'h12345678);
        set(2, 2'b10, 1'b0, 32'h20, 32'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            set(2, 2'b10, 1'(k), 32'h3C - 32'(k), 32'hFFFF0000);
            tick();
        end
        set(2, 2'b00, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        // errors: misaligned in range, exact limit, misaligned and out of range
        single(0, 1'b1, 32'h3C, 32'h0BADF00D);
        single(0, 1'b1, 32'h3E, 32'h11111111);
        single(0, 1'b1, 32'(LIM), 32'h22222222);
        single(0, 1'b1, 32'h402, 32'h33333333);
        single(0, 1'b0, 32'h3C, 32'h0);
        // pipelined reads with a BUSY in between
        single(0, 1'b1, 32'h0, 32'hA0000000);
        single(0, 1'b1, 32'h4, 32'hA0000004);
        single(0, 1'b1, 32'h8, 32'hA0000008);
        set(0, 2'b10, 1'b0, 32'h0, 32'h0);
        tick();
        set(0, 2'b11, 1'b0, 32'h4, 32'h0);
        tick();
        set(0, 2'b01, 1'b0, 32'h8, 32'h0);
        tick();
        set(0, 2'b11, 1'b0, 32'h8, 32'h0);
        tick();
        set(0, 2'b00, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        // reset in the middle of a wait-stated write leaves the old word
        single(1, 1'b1, 32'h30, 32'hA5A5A5A5);
        set(1, 2'b10, 1'b1, 32'h30, 32'h0);
        tick();
        set(1, 2'b00, 1'b0, 32'h0, 32'h5A5A5A5A);
        tick();
        do_reset();
        single(1, 1'b0, 32'h30, 32'h0);
        check("u1.reset_keeps_old", 32'(kn[1][12]), 32'd1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            else begin
                for (int d = 0; d < 3; d++) drive_rand(d);
                tick();
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
